hmmm_serial_loader: RTL and testbench
=====================================

Name: hmmm_serial_loader

Overview:
Parametrised successor to the Hmmm core's two-pin program-load interface. Receives framed, bursted program images over three asynchronous GPIO pins: a serial clock, a frame select and a data line. Writes each received word into Hmmm instruction memory through a ready/valid write port. Verifies a per-frame XOR checksum and holds the core in load (`loading`) until the burst completes or fails.

Parameters:
ADDR_W, 8, instruction memory address width; also the width of the header address field.
DATA_W, 16, instruction word width; also the width of the data and checksum fields.
COUNT_W, 8, width of the header length field (word count per frame).
SYNC_STAGES, 2, synchronizer flops on each pin input (minimum 2).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
pgrm_clk  input  1  asynchronous serial shift clock pin; data is sampled on its rising edge
pgrm_sel  input  1  asynchronous frame select pin; high for the duration of a frame
pgrm_data  input  1  asynchronous serial data pin, MSB-first
mem_we  output  1  write request (valid)
mem_ready  input  1  memory accepts the write in any cycle where mem_we && mem_ready
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
loading  output  1  a frame is in progress; the core is held
done  output  1  sticky: last frame completed with a good checksum
err  output  1  sticky: last frame failed
err_code  output  2  01 = checksum mismatch, 10 = abort (sel fell early), 11 = overrun
word_count  output  COUNT_W  number of words written in the current or last frame

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchronizers cleared, pending write dropped. Reset mid-frame abandons the frame with no error flagged.
- Pin handling:
  - Each pin passes through SYNC_STAGES flops.
  - A pgrm_clk rising edge is detected from the last two synced samples; the bit is taken from synced pgrm_data in that same cycle.
  - Edge-to-capture latency is SYNC_STAGES+1 clk cycles.
  - pgrm_clk high and low times must each be at least SYNC_STAGES+1 clk cycles.
- Frame start: a synced pgrm_sel rising edge in any state (or sel already high on leaving reset) does the following:
  - clears done, err, err_code, word_count and the checksum accumulator;
  - sets loading = 1;
  - enters ADDR.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM, DONE, ERR.
  - ADDR: shift ADDR_W bits into the address register, then go to LEN.
  - LEN: shift COUNT_W bits into L. If L = 0, go to CSUM; otherwise go to DATA.
  - DATA: shift DATA_W bits per word. When a word completes:
    - present it on mem_wdata / mem_addr with mem_we = 1 in the next cycle;
    - XOR it into the accumulator.
    - After L words, go to CSUM.
  - CSUM: shift DATA_W bits, then compare with the accumulator.
    - Equal: go to DONE and set done = 1.
    - Not equal: go to ERR with code 01.
  - DONE / ERR: further pgrm_clk edges are ignored. A sel falling edge goes to IDLE; done, err and err_code hold.
- Write handshake:
  - mem_we, mem_addr and mem_wdata hold stable until the cycle where mem_ready = 1.
  - On acceptance:
    - mem_we drops the next cycle unless another word is already queued;
    - mem_addr increments modulo 2^ADDR_W (0xFF wraps to 0x00);
    - word_count increments.
  - Single-entry holding buffer. If a new word completes while a write is still pending, go to ERR with code 11; the pending write still completes and the new word is dropped.
- Abort: a sel falling edge while in ADDR, LEN, DATA or CSUM goes to ERR with code 10; a partial word is discarded.
- loading deasserts the cycle after the FSM reaches DONE or ERR with no write pending.
- Simultaneous events:
  - sel falling edge and clk rising edge in the same cycle: the falling edge wins and the bit is discarded.
  - Write acceptance and completion of a new word in the same cycle: this is not an overrun.

Test Plan:
- Basic frame: addr 0x10, L = 2, words 0x1234, 0xABCD, checksum 0xB9F9, mem_ready tied 1.
  → writes (0x10, 0x1234) then (0x11, 0xABCD); done = 1, err = 0, word_count = 2, loading falls.
- Bad checksum: same frame with checksum 0x0000.
  → both words written; err = 1, err_code = 01, done = 0.
- Empty and wrap:
  - L = 0, checksum 0x0000 → no mem_we, done = 1.
  - addr 0xFF, L = 2, words 0x0001, 0x0002, checksum 0x0003 → writes to 0xFF then 0x00.
- Back-pressure: mem_ready low for 5 cycles on the first write, with the serial clock slow enough.
  → mem_we/mem_addr/mem_wdata stable throughout, no error.
  - Hold mem_ready low past the next word's completion → err_code = 11, exactly 1 word written.
- Abort and reset:
  - Drop sel after 5 data bits → err_code = 10, no write issued.
  - Separately, assert rst mid-DATA → all outputs 0 the next cycle. A fresh frame after reset completes normally.

Source files
------------

// File: rtl/hmmm_serial_loader.sv
`timescale 1ns/1ps
// hmmm_serial_loader
// Receives framed program images over three asynchronous GPIO pins and writes
// each received word into Hmmm instruction memory through a ready/valid port.
//
// Frame layout, shifted MSB-first on rising pgrm_clk while pgrm_sel is high:
//   ADDR_W bits start address, COUNT_W bits word count L,
//   L x DATA_W bits data words, DATA_W bits XOR checksum of the data words.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pgrm_clk/sel/data   asynchronous serial pins (shift clock, frame select, data)
//   mem_we/mem_ready    write valid / ready handshake
//   mem_addr/mem_wdata  write address / data, held stable while mem_we && !mem_ready
//   loading             frame in progress, core held
//   done/err/err_code   sticky frame result (01 checksum, 10 abort, 11 overrun)
//   word_count          words accepted by memory in the current or last frame
module hmmm_serial_loader #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int COUNT_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pgrm_clk,
    input  logic               pgrm_sel,
    input  logic               pgrm_data,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               loading,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [COUNT_W-1:0] word_count
);

    // Shift register is sized for the widest field of the frame.
    localparam int SHIFT_W = (DATA_W >= ADDR_W) ?
                             ((DATA_W >= COUNT_W) ? DATA_W : COUNT_W) :
                             ((ADDR_W >= COUNT_W) ? ADDR_W : COUNT_W);
    localparam int BC_W = $clog2(SHIFT_W + 1);

    localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(ADDR_W - 1);
    localparam logic [BC_W-1:0] LEN_LAST  = BC_W'(COUNT_W - 1);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers: index 0 = pgrm_clk, 1 = pgrm_sel, 2 = pgrm_data
    // ------------------------------------------------------------------
    logic [2:0]             pin_raw;
    logic [2:0]             pin_s;
    logic [SYNC_STAGES-1:0] sync_reg [3];

    assign pin_raw = {pgrm_data, pgrm_sel, pgrm_clk};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= '0;
                end else begin
                    sync_reg[gi] <= {sync_reg[gi][SYNC_STAGES-2:0], pin_raw[gi]};
                end
            end
            assign pin_s[gi] = sync_reg[gi][SYNC_STAGES-1];
        end
    endgenerate

    logic sclk_prev_reg;
    logic sel_prev_reg;
    logic clk_rise;
    logic sel_rise;
    logic sel_fall;
    logic data_s;

    assign clk_rise = pin_s[0] & ~sclk_prev_reg;
    assign sel_rise = pin_s[1] & ~sel_prev_reg;
    assign sel_fall = ~pin_s[1] & sel_prev_reg;
    assign data_s   = pin_s[2];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               state_reg,      state_next;
    logic [SHIFT_W-2:0]   shift_reg,      shift_next;
    logic [BC_W-1:0]      bit_cnt_reg,    bit_cnt_next;
    logic [COUNT_W-1:0]   len_reg,        len_next;
    logic [COUNT_W-1:0]   rcvd_reg,       rcvd_next;
    logic [DATA_W-1:0]    csum_reg,       csum_next;
    logic [ADDR_W-1:0]    wr_addr_reg,    wr_addr_next;
    logic [DATA_W-1:0]    wdata_reg,      wdata_next;
    logic                 we_reg,         we_next;
    logic [COUNT_W-1:0]   word_count_reg, word_count_next;
    logic                 done_reg,       done_next;
    logic                 err_reg,        err_next;
    logic [1:0]           err_code_reg,   err_code_next;
    logic                 loading_reg,    loading_next;

    logic [SHIFT_W-1:0]   word_full;
    logic [COUNT_W-1:0]   rcvd_inc;
    logic                 accept;

    // Field value including the bit arriving this cycle.
    assign word_full = {shift_reg, data_s};
    assign rcvd_inc  = rcvd_reg + COUNT_W'(1);
    assign accept    = we_reg & mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_reg  <= 1'b0;
            sel_prev_reg   <= 1'b0;
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            len_reg        <= '0;
            rcvd_reg       <= '0;
            csum_reg       <= '0;
            wr_addr_reg    <= '0;
            wdata_reg      <= '0;
            we_reg         <= 1'b0;
            word_count_reg <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            err_code_reg   <= 2'b00;
            loading_reg    <= 1'b0;
        end else begin
            sclk_prev_reg  <= pin_s[0];
            sel_prev_reg   <= pin_s[1];
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            len_reg        <= len_next;
            rcvd_reg       <= rcvd_next;
            csum_reg       <= csum_next;
            wr_addr_reg    <= wr_addr_next;
            wdata_reg      <= wdata_next;
            we_reg         <= we_next;
            word_count_reg <= word_count_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            err_code_reg   <= err_code_next;
            loading_reg    <= loading_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        len_next        = len_reg;
        rcvd_next       = rcvd_reg;
        csum_next       = csum_reg;
        wr_addr_next    = wr_addr_reg;
        wdata_next      = wdata_reg;
        we_next         = we_reg;
        word_count_next = word_count_reg;
        done_next       = done_reg;
        err_next        = err_reg;
        err_code_next   = err_code_reg;
        loading_next    = loading_reg;

        // Memory handshake: the output register is the single holding slot.
        if (accept) begin
            we_next         = 1'b0;
            wr_addr_next    = wr_addr_reg + ADDR_W'(1);
            word_count_next = word_count_reg + COUNT_W'(1);
        end

        // Release the core once the frame has ended and nothing is in flight.
        if ((state_reg == DONE || state_reg == ERR) && !we_reg) begin
            loading_next = 1'b0;
        end

        if (sel_rise) begin
            state_next      = ADDR;
            bit_cnt_next    = '0;
            rcvd_next       = '0;
            csum_next       = '0;
            word_count_next = '0;
            done_next       = 1'b0;
            err_next        = 1'b0;
            err_code_next   = 2'b00;
            loading_next    = 1'b1;
        end else if (sel_fall) begin
            // A falling select takes priority over a coincident clock edge.
            case (state_reg)
                ADDR, LEN, DATA, CSUM: begin
                    state_next    = ERR;
                    err_next      = 1'b1;
                    err_code_next = 2'b10;
                end
                DONE, ERR: state_next = IDLE;
                default: ;
            endcase
        end else if (clk_rise) begin
            case (state_reg)
                ADDR: begin
                    shift_next   = word_full[SHIFT_W-2:0];
                    bit_cnt_next = bit_cnt_reg + BC_W'(1);
                    if (bit_cnt_reg == ADDR_LAST) begin
                        bit_cnt_next = '0;
                        wr_addr_next = word_full[ADDR_W-1:0];
                        state_next   = LEN;
                    end
                end
                LEN: begin
                    shift_next   = word_full[SHIFT_W-2:0];
                    bit_cnt_next = bit_cnt_reg + BC_W'(1);
                    if (bit_cnt_reg == LEN_LAST) begin
                        bit_cnt_next = '0;
                        len_next     = word_full[COUNT_W-1:0];
                        state_next   = (word_full[COUNT_W-1:0] == '0) ? CSUM : DATA;
                    end
                end
                DATA: begin
                    shift_next   = word_full[SHIFT_W-2:0];
                    bit_cnt_next = bit_cnt_reg + BC_W'(1);
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
                        if (we_reg && !mem_ready) begin
                            // Slot still occupied: keep the pending write, drop this word.
                            state_next    = ERR;
                            err_next      = 1'b1;
                            err_code_next = 2'b11;
                        end else begin
                            we_next    = 1'b1;
                            wdata_next = word_full[DATA_W-1:0];
                            csum_next  = csum_reg ^ word_full[DATA_W-1:0];
                            rcvd_next  = rcvd_inc;
                            if (rcvd_inc == len_reg) begin
                                state_next = CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    shift_next   = word_full[SHIFT_W-2:0];
                    bit_cnt_next = bit_cnt_reg + BC_W'(1);
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
                        if (word_full[DATA_W-1:0] == csum_reg) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end else begin
                            state_next    = ERR;
                            err_next      = 1'b1;
                            err_code_next = 2'b01;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we     = we_reg;
    assign mem_addr   = wr_addr_reg;
    assign mem_wdata  = wdata_reg;
    assign loading    = loading_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign err_code   = err_code_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_hmmm_serial_loader.sv
`timescale 1ns/1ps
// Self-checking bench for hmmm_serial_loader: directed frames plus random
// frames; expected memory writes go into a scoreboard queue, a monitor pops
// and compares on every accepted write.
module tb_hmmm_serial_loader;

    localparam int HALF = 4;  // serial clock half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pgrm_clk = 1'b0;
    logic        pgrm_sel = 1'b0;
    logic        pgrm_data = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        loading;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  word_count;

    always #5 clk = ~clk;

    hmmm_serial_loader dut (
        .clk        (clk),
        .rst        (rst),
        .pgrm_clk   (pgrm_clk),
        .pgrm_sel   (pgrm_sel),
        .pgrm_data  (pgrm_data),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .loading    (loading),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .word_count (word_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];

    // mem_ready modes: 0 always ready, 1 random, 2 stall for stall_n cycles of mem_we
    int ready_mode = 0;
    int stall_n    = 0;
    int stall_cnt  = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic send_bit(input logic b);
        pgrm_data = b;
        tick(HALF);
        pgrm_clk = 1'b1;
        tick(HALF);
        pgrm_clk = 1'b0;
    endtask

    task automatic send_field(input logic [31:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic begin_frame();
        pgrm_sel = 1'b1;
        tick(HALF + 1);
    endtask

    task automatic end_check(input string name, input logic e_done, input logic e_err,
                             input logic [1:0] e_code, input logic [7:0] e_cnt);
        int t;
        t = 0;
        tick(2);
        while (loading && t < 3000) begin
            tick(1);
            t++;
        end
        if (t >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_loading_timeout: loading still %0b after %0d cycles, required 0", name, loading, t);
        end
        chk({name, "_result"}, {done, err, err_code, word_count}, {e_done, e_err, e_code, e_cnt});
        pgrm_sel = 1'b0;
        tick(HALF + 3);
        chk({name, "_sticky_after_sel"}, {loading, done, err, err_code}, {1'b0, e_done, e_err, e_code});
        chk({name, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Reference model: writes are consecutive addresses (mod 256) starting at
    // the header address; result is good iff checksum equals the XOR of the words.
    task automatic frame(input string name, input logic [7:0] a, input int n,
                         input logic [15:0] w[8], input logic [15:0] cs);
        logic [15:0] x;
        logic        good;
        x = 16'h0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{a: 8'(a + 8'(i)), d: w[i]});
            x = x ^ w[i];
        end
        good = (x == cs);
        begin_frame();
        send_field(32'(a), 8);
        send_field(32'(n), 8);
        for (int i = 0; i < n; i++) send_field(32'(w[i]), 16);
        send_field(32'(cs), 16);
        end_check(name, good, !good, good ? 2'b00 : 2'b01, 8'(n));
    endtask

    // mem_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: mem_ready = 1'b1;
                1: mem_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (stall_cnt >= stall_n) begin
                        mem_ready = 1'b1;
                    end else begin
                        mem_ready = 1'b0;
                        if (mem_we) stall_cnt++;
                    end
                end
            endcase
        end
    end

    // Monitor: compare every accepted write, and check that a pending write holds.
    initial begin
        logic        prev_pend;
        logic [7:0]  prev_addr;
        logic [15:0] prev_data;
        wr_t         e;
        prev_pend = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pend = 1'b0;
            end else if (mem_we) begin
                if (prev_pend) begin
                    n_cmp++;
                    if (mem_addr !== prev_addr || mem_wdata !== prev_data) begin
                        n_bad++;
                        $display("FAIL write_hold: got %0h/%0h required %0h/%0h",
                                 mem_addr, mem_wdata, prev_addr, prev_data);
                    end
                end
                if (mem_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_write: got %0h/%0h required none", mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_addr !== e.a || mem_wdata !== e.d) begin
                            n_bad++;
                            $display("FAIL write: got addr %0h data %0h required addr %0h data %0h",
                                     mem_addr, mem_wdata, e.a, e.d);
                        end else begin
                            $display("ok   write addr %0h data %0h", mem_addr, mem_wdata);
                        end
                    end
                end
                prev_pend = !mem_ready;
                prev_addr = mem_addr;
                prev_data = mem_wdata;
            end else begin
                if (prev_pend) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL write_withdrawn: mem_we 0 required 1 (addr %0h)", prev_addr);
                end
                prev_pend = 1'b0;
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w[8];
        logic [15:0] x;
        logic [7:0]  a;
        int          n;

        for (int i = 0; i < 8; i++) w[i] = 16'h0;

        rst = 1'b1;
        tick(4);
        chk("reset_outputs",
            64'({mem_we, loading, done, err, err_code, word_count, mem_addr, mem_wdata}), 64'd0);
        rst = 1'b0;
        tick(3);

        // Basic frame
        w[0] = 16'h1234; w[1] = 16'hABCD;
        frame("basic", 8'h10, 2, w, 16'hB9F9);

        // Bad checksum
        frame("bad_csum", 8'h10, 2, w, 16'h0000);

        // Empty frame
        frame("empty", 8'h55, 0, w, 16'h0000);

        // Address wrap
        w[0] = 16'h0001; w[1] = 16'h0002;
        frame("wrap", 8'hFF, 2, w, 16'h0003);

        // Back-pressure: 5 stall cycles on the first write
        stall_cnt = 0; stall_n = 5; ready_mode = 2;
        tick(2);
        w[0] = 16'h1234; w[1] = 16'hABCD;
        frame("backpressure", 8'h10, 2, w, 16'hB9F9);

        // Overrun: first write stalled past completion of the second word
        stall_cnt = 0; stall_n = 200; ready_mode = 2;
        tick(2);
        exp_q.push_back('{a: 8'h20, d: 16'h1111});
        begin_frame();
        send_field(32'h20, 8);
        send_field(32'd2, 8);
        send_field(32'h1111, 16);
        send_field(32'h2222, 16);
        end_check("overrun", 1'b0, 1'b1, 2'b11, 8'd1);
        ready_mode = 0;
        tick(2);

        // Abort after 5 data bits
        begin_frame();
        send_field(32'h30, 8);
        send_field(32'd2, 8);
        send_field(32'h15, 5);
        pgrm_sel = 1'b0;
        end_check("abort", 1'b0, 1'b1, 2'b10, 8'd0);

        // Reset mid-DATA
        begin_frame();
        send_field(32'h40, 8);
        send_field(32'd3, 8);
        send_field(32'h5A, 7);
        rst = 1'b1;
        pgrm_sel = 1'b0;
        pgrm_clk = 1'b0;
        tick(1);
        chk("midframe_reset_outputs",
            64'({mem_we, loading, done, err, err_code, word_count, mem_addr, mem_wdata}), 64'd0);
        rst = 1'b0;
        tick(3);
        w[0] = 16'hBEEF; w[1] = 16'h0F0F; w[2] = 16'h1357;
        frame("after_reset", 8'h40, 3, w, 16'hBEEF ^ 16'h0F0F ^ 16'h1357);

        // Random frames with random back-pressure
        ready_mode = 1;
        for (int f = 0; f < 8; f++) begin
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            x = 16'h0;
            for (int i = 0; i < n; i++) begin
                w[i] = 16'($urandom_range(0, 65535));
                x = x ^ w[i];
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 16'($urandom_range(1, 65535));
            frame($sformatf("random%0d", f), a, n, w, x);
        end
        ready_mode = 0;
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
